// File: rtl/accumulate_to_bcd_display.sv
// Running-sum accumulator with selectable overflow policy, double-dabble BCD
// conversion and registered 7-segment outputs for DIGITS decimal digits.
module accumulate_to_bcd_display #(
    parameter int DIGITS = 2,
    parameter int W      = 3,
    parameter int MODE   = 0,
    parameter int BLANK  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           s_data,
    input  logic                   clr,
    output logic [DIGITS-1:0][6:0] m_data,
    output logic [DIGITS*4-1:0]    m_bcd,
    output logic                   m_valid,
    output logic                   overflow
);

    localparam int MAX   = 10**DIGITS - 1;
    localparam int ACC_W = $clog2(MAX + 1);
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int BCD_W = DIGITS * 4;
    localparam logic [ACC_W:0]   MAX_EXT = (ACC_W + 1)'(MAX);
    localparam logic [ACC_W-1:0] MOD_W   = ACC_W'(MAX + 1);

    if (2**W - 1 > MAX) begin : g_bad_width
        $error("sample width W too large for DIGITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h7E;
            4'd1:    p = 7'h30;
            4'd2:    p = 7'h6D;
            4'd3:    p = 7'h79;
            4'd4:    p = 7'h33;
            4'd5:    p = 7'h5B;
            4'd6:    p = 7'h5F;
            4'd7:    p = 7'h70;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h7B;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            else                     r[i*4 +: 4] = b[i*4 +: 4];
        end
        return r;
    endfunction

    // Walk from the most significant digit down; blank while still in leading zeros.
    function automatic logic [DIGITS-1:0][6:0] encode(input logic [BCD_W-1:0] b);
        logic [DIGITS-1:0][6:0] p;
        logic                   lead;
        lead = (BLANK != 0);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && (i > 0) && (b[i*4 +: 4] == 4'd0)) begin
                p[i] = 7'h00;
            end else begin
                p[i] = seg7(b[i*4 +: 4]);
                lead = 1'b0;
            end
        end
        return p;
    endfunction

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid_q, m_valid_d;
    logic [BCD_W-1:0]       m_bcd_q, m_bcd_d;
    logic [DIGITS-1:0][6:0] m_data_q, m_data_d;

    logic                   accept_s;
    logic [ACC_W:0]         sum_s;
    logic [ACC_W-1:0]       wrap_s;
    logic [BCD_W-1:0]       dab_s;
    logic [BCD_W+ACC_W-1:0] shift_s;

    assign accept_s = s_valid && s_ready_q;
    assign sum_s    = {1'b0, acc_q} + (ACC_W + 1)'(s_data);
    assign wrap_s   = sum_s[ACC_W-1:0] - MOD_W;
    assign dab_s    = add3(bcd_q);
    assign shift_s  = {dab_s, bin_q} << 1;

    // Next-state: accumulate, convert, publish; clr restarts a conversion of zero.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        s_ready_d = s_ready_q;
        m_valid_d = 1'b0;
        m_bcd_d   = m_bcd_q;
        m_data_d  = m_data_q;
        if (clr) begin
            acc_d     = {ACC_W{1'b0}};
            ovf_d     = 1'b0;
            bin_d     = {ACC_W{1'b0}};
            bcd_d     = {BCD_W{1'b0}};
            cnt_d     = CNT_W'(ACC_W);
            state_d   = ST_CONV;
            s_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (sum_s > MAX_EXT) begin
                            ovf_d = 1'b1;
                            case (MODE)
                                1:       acc_d = MAX_EXT[ACC_W-1:0];
                                2:       acc_d = {ACC_W{1'b0}};
                                default: acc_d = wrap_s;
                            endcase
                        end else begin
                            acc_d = sum_s[ACC_W-1:0];
                        end
                        bin_d     = acc_d;
                        bcd_d     = {BCD_W{1'b0}};
                        cnt_d     = CNT_W'(ACC_W);
                        state_d   = ST_CONV;
                        s_ready_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CONV: begin
                    {bcd_d, bin_d} = shift_s;
                    cnt_d          = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
                    else                    state_d = ST_CONV;
                end
                ST_LOAD: begin
                    m_bcd_d   = bcd_q;
                    m_data_d  = encode(bcd_q);
                    m_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                    s_ready_d = 1'b1;
                end
                default: begin
                    state_d   = ST_IDLE;
                    s_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            bin_q     <= {ACC_W{1'b0}};
            bcd_q     <= {BCD_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_bcd_q   <= {BCD_W{1'b0}};
            for (int i = 0; i < DIGITS; i++) begin
                m_data_q[i] <= ((BLANK != 0) && (i > 0)) ? 7'h00 : 7'h7E;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_bcd_q   <= m_bcd_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_bcd    = m_bcd_q;
    assign m_data   = m_data_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_accumulate_to_bcd_display.sv
// Four configurations (wrap, saturate, clear, 4-digit blanked) driven by directed
// and random transactions, compared against an arithmetic decimal model.
module tb_accumulate_to_bcd_display;

    logic        clk;
    logic        rst;
    logic        s_valid_a [4];
    logic [2:0]  s_data_a  [4];
    logic        clr_a     [4];
    logic        s_ready_a [4];
    logic        m_valid_a [4];
    logic        ovf_a     [4];
    logic [13:0] md0, md1, md2;
    logic [27:0] md3;
    logic [7:0]  bc0, bc1, bc2;
    logic [15:0] bc3;
    logic [27:0] mdata_a [4];
    logic [15:0] mbcd_a  [4];

    int dig  [4] = '{2, 2, 2, 4};
    int maxv [4] = '{99, 99, 99, 9999};
    int accw [4] = '{7, 7, 7, 14};
    int mode [4] = '{0, 1, 2, 0};
    int blk  [4] = '{0, 0, 0, 1};
    logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int ref_acc   [4];
    int ref_shown [4];
    bit ref_ovf   [4];
    int n_tests = 0;
    int n_fail  = 0;

    accumulate_to_bcd_display #(.DIGITS(2), .W(3), .MODE(0), .BLANK(0)) u_wrap (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[0]), .s_ready(s_ready_a[0]),
        .s_data(s_data_a[0]), .clr(clr_a[0]), .m_data(md0), .m_bcd(bc0),
        .m_valid(m_valid_a[0]), .overflow(ovf_a[0]));
    accumulate_to_bcd_display #(.DIGITS(2), .W(3), .MODE(1), .BLANK(0)) u_sat (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[1]), .s_ready(s_ready_a[1]),
        .s_data(s_data_a[1]), .clr(clr_a[1]), .m_data(md1), .m_bcd(bc1),
        .m_valid(m_valid_a[1]), .overflow(ovf_a[1]));
    accumulate_to_bcd_display #(.DIGITS(2), .W(3), .MODE(2), .BLANK(0)) u_clr (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[2]), .s_ready(s_ready_a[2]),
        .s_data(s_data_a[2]), .clr(clr_a[2]), .m_data(md2), .m_bcd(bc2),
        .m_valid(m_valid_a[2]), .overflow(ovf_a[2]));
    accumulate_to_bcd_display #(.DIGITS(4), .W(3), .MODE(0), .BLANK(1)) u_blank (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[3]), .s_ready(s_ready_a[3]),
        .s_data(s_data_a[3]), .clr(clr_a[3]), .m_data(md3), .m_bcd(bc3),
        .m_valid(m_valid_a[3]), .overflow(ovf_a[3]));

    assign mdata_a[0] = {14'h0, md0};
    assign mdata_a[1] = {14'h0, md1};
    assign mdata_a[2] = {14'h0, md2};
    assign mdata_a[3] = md3;
    assign mbcd_a[0]  = {8'h0, bc0};
    assign mbcd_a[1]  = {8'h0, bc1};
    assign mbcd_a[2]  = {8'h0, bc2};
    assign mbcd_a[3]  = bc3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_bcd(input int k, input int val);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < dig[k]; i++) begin
            r[i*4 +: 4] = 4'((val / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_seg(input int k, input int val);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < dig[k]; i++) begin
            if (blk[k] != 0 && i > 0 && val < p) r[i*7 +: 7] = 7'h00;
            else                                  r[i*7 +: 7] = seg_tab[(val / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_accept(input int k, input int v);
        int sum;
        sum = ref_acc[k] + v;
        if (sum > maxv[k]) begin
            ref_ovf[k] = 1'b1;
            case (mode[k])
                0:       sum = sum - (maxv[k] + 1);
                1:       sum = maxv[k];
                default: sum = 0;
            endcase
        end
        ref_acc[k] = sum;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            ref_acc[k]   = 0;
            ref_shown[k] = 0;
            ref_ovf[k]   = 1'b0;
        end
    endtask

    task automatic check_outputs(input int k, input string tag);
        check_eq($sformatf("%s_u%0d_bcd", tag, k), 32'(mbcd_a[k]), exp_bcd(k, ref_shown[k]));
        check_eq($sformatf("%s_u%0d_seg", tag, k), 32'(mdata_a[k]), exp_seg(k, ref_shown[k]));
        check_eq($sformatf("%s_u%0d_ovf", tag, k), 32'(ovf_a[k]), 32'(ref_ovf[k]));
    endtask

    // One accept; optional clr 'off' edges later (0 = same edge as the accept).
    task automatic txn(input int k, input int v, input bit do_clr, input int off);
        int pulse;
        pulse = do_clr ? off + accw[k] + 1 : accw[k] + 1;
        check_eq($sformatf("u%0d_ready_pre", k), 32'(s_ready_a[k]), 32'd1);
        s_valid_a[k] = 1'b1;
        s_data_a[k]  = 3'(v);
        clr_a[k]     = do_clr && (off == 0);
        @(posedge clk);
        #1;
        model_accept(k, v);
        if (do_clr) begin
            ref_acc[k] = 0;
            ref_ovf[k] = 1'b0;
        end
        s_valid_a[k] = 1'b0;
        s_data_a[k]  = 3'($urandom_range(0, 7));
        clr_a[k]     = do_clr && (off == 1);
        for (int e = 1; e <= pulse + 1; e++) begin
            @(posedge clk);
            #1;
            clr_a[k] = do_clr && (e + 1 == off);
            if (e == pulse) ref_shown[k] = ref_acc[k];
            check_eq($sformatf("u%0d_mvalid_e%0d", k, e), 32'(m_valid_a[k]), 32'(e == pulse));
            check_eq($sformatf("u%0d_ready_e%0d", k, e), 32'(s_ready_a[k]), 32'(e >= pulse));
            check_eq($sformatf("u%0d_hold_e%0d", k, e), 32'(mbcd_a[k]), exp_bcd(k, ref_shown[k]));
        end
        check_outputs(k, "txn");
    endtask

    // s_valid held high with data 1 for n accepts.
    task automatic stream(input int k, input int n);
        int p;
        p = accw[k] + 2;
        s_valid_a[k] = 1'b1;
        s_data_a[k]  = 3'd1;
        for (int e = 0; e < n * p; e++) begin
            @(posedge clk);
            #1;
            if (e % p == 0) model_accept(k, 1);
            if (e % p == p - 1) ref_shown[k] = ref_acc[k];
            check_eq($sformatf("stream_u%0d_mvalid_e%0d", k, e), 32'(m_valid_a[k]), 32'(e % p == p - 1));
            check_eq($sformatf("stream_u%0d_ready_e%0d", k, e), 32'(s_ready_a[k]), 32'(e % p == p - 1));
            check_eq($sformatf("stream_u%0d_bcd_e%0d", k, e), 32'(mbcd_a[k]), exp_bcd(k, ref_shown[k]));
        end
        s_valid_a[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid_a[k] = 1'b0;
            s_data_a[k]  = 3'd0;
            clr_a[k]     = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rst_u%0d_mvalid", k), 32'(m_valid_a[k]), 32'd0);
            check_eq($sformatf("rst_u%0d_ready", k), 32'(s_ready_a[k]), 32'd1);
            check_outputs(k, "rst");
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 7 x14 then 5 = 103 under wrap, saturate and clear
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 14; j++) txn(k, 7, 1'b0, 0);
            txn(k, 5, 1'b0, 0);
        end
        check_eq("wrap_bcd", 32'(mbcd_a[0]), 32'h03);
        check_eq("wrap_seg", 32'(mdata_a[0]), 32'({7'h7E, 7'h79}));
        check_eq("sat_bcd", 32'(mbcd_a[1]), 32'h99);
        check_eq("sat_seg", 32'(mdata_a[1]), 32'({7'h7B, 7'h7B}));
        check_eq("clr_bcd", 32'(mbcd_a[2]), 32'h00);
        check_eq("clr_seg", 32'(mdata_a[2]), 32'({7'h7E, 7'h7E}));
        check_eq("sat_ovf", 32'(ovf_a[1]), 32'd1);

        txn(3, 7, 1'b0, 0);
        check_eq("blank7_seg", 32'(mdata_a[3]), 32'({7'h00, 7'h00, 7'h00, 7'h70}));
        check_eq("blank7_bcd", 32'(mbcd_a[3]), 32'h0007);
        txn(3, 3, 1'b0, 0);
        check_eq("blank10_seg", 32'(mdata_a[3]), 32'({7'h00, 7'h00, 7'h30, 7'h7E}));

        txn(0, 6, 1'b1, 3);
        check_eq("clr_mid_ovf", 32'(ovf_a[0]), 32'd0);
        txn(0, 5, 1'b1, 0);
        check_eq("clr_idle_bcd", 32'(mbcd_a[0]), 32'h00);

        stream(0, 5);
        check_eq("stream_final", 32'(mbcd_a[0]), 32'h05);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 30; j++) begin
                txn(k, int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, accw[k] + 1)));
            end
        end

        // Reset in the middle of a conversion
        s_valid_a[0] = 1'b1;
        s_data_a[0]  = 3'd4;
        @(posedge clk);
        #1;
        s_valid_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_ready", 32'(s_ready_a[0]), 32'd1);
        check_eq("midrst_mvalid", 32'(m_valid_a[0]), 32'd0);
        check_outputs(0, "midrst");
        check_outputs(3, "midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("postrst_mvalid_e%0d", e), 32'(m_valid_a[0]), 32'd0);
        end
        txn(0, 4, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
